// File: rtl/perceptron_bp_pkg.sv
// Shared types and fixed-point helpers for the perceptron backprop engine.
// Width/Frac here must match the WIDTH/FRAC parameters of perceptron_bp.
package perceptron_bp_pkg;

    localparam int unsigned Width = 32;
    localparam int unsigned Frac  = 16;

    localparam logic [Width-1:0] One    = Width'(64'd1 << Frac);
    localparam logic [Width-1:0] SatMax = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] SatMin = {1'b1, {(Width-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StDer1, StDer2, StLrd, StUpd, StProp, StDone
    } state_e;

    // One guard bit catches signed overflow; clamp toward the true result's sign.
    function automatic logic [Width-1:0] sat_add(input logic [Width-1:0] x,
                                                 input logic [Width-1:0] y);
        logic [Width:0] s;
        s = {x[Width-1], x} + {y[Width-1], y};
        if (s[Width] != s[Width-1]) return s[Width] ? SatMin : SatMax;
        return s[Width-1:0];
    endfunction

    function automatic logic [Width-1:0] sat_sub(input logic [Width-1:0] x,
                                                 input logic [Width-1:0] y);
        logic [Width:0] s;
        s = {x[Width-1], x} - {y[Width-1], y};
        if (s[Width] != s[Width-1]) return s[Width] ? SatMin : SatMax;
        return s[Width-1:0];
    endfunction

endpackage

// File: rtl/perceptron_bp_mult.sv
// Combinational signed fixed-point multiply: full product, arithmetic shift by FRAC,
// saturate to WIDTH bits.
module mult_fx #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] p_o
);

    logic signed [2*WIDTH-1:0] xe, ye, prod, shr;
    logic [WIDTH:0]            hi;
    logic                      ovf;

    assign xe   = $signed({{WIDTH{x_i[WIDTH-1]}}, x_i});
    assign ye   = $signed({{WIDTH{y_i[WIDTH-1]}}, y_i});
    assign prod = xe * ye;
    assign shr  = prod >>> FRAC;
    // Result fits only if everything above the kept sign bit is sign extension.
    assign hi   = shr[2*WIDTH-1:WIDTH-1];
    assign ovf  = !((&hi) || !(|hi));

    always_comb begin
        p_o = shr[WIDTH-1:0];
        if (ovf) p_o = shr[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

endmodule

// File: rtl/perceptron_bp.sv
// Backprop/weight-update engine for one perceptron; a single shared fixed-point
// multiplier is stepped through delta, update and error-propagation phases.
module perceptron_bp
    import perceptron_bp_pkg::*;
#(
    parameter int unsigned NUM   = 2,
    parameter int unsigned WIDTH = Width,
    parameter int unsigned FRAC  = Frac
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [NUM*WIDTH-1:0]     i_k,
    input  logic [NUM*WIDTH-1:0]     i_w,
    input  logic [WIDTH-1:0]         i_b,
    input  logic [WIDTH-1:0]         i_a,
    input  logic [WIDTH-1:0]         i_err,
    input  logic [WIDTH-1:0]         i_lr,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_wr,
    output logic [(NUM+1)*WIDTH-1:0] o_w,
    output logic [NUM*WIDTH-1:0]     o_err
);

    localparam int unsigned IdxW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;

    logic [WIDTH-1:0] k_q [NUM];
    logic [WIDTH-1:0] w_q [NUM];
    logic [WIDTH-1:0] wnew_q [NUM];
    logic [WIDTH-1:0] perr_q [NUM];
    logic [WIDTH-1:0] b_q, a_q, err_q, lr_q, t_q, delta_q, ld_q;
    logic [WIDTH-1:0] mul_x, mul_y, mul_p;

    logic                     busy_q, done_q;
    logic [(NUM+1)*WIDTH-1:0] w_out_q;
    logic [NUM*WIDTH-1:0]     err_out_q;

    mult_fx #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .x_i (mul_x),
        .y_i (mul_y),
        .p_o (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: if (i_start) state_d = StDer1;
            StDer1: state_d = StDer2;
            StDer2: state_d = StLrd;
            StLrd: begin
                state_d = StUpd;
                idx_d   = '0;
            end
            StUpd: begin
                if (idx_q == LastIdx) begin
                    state_d = StProp;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StProp: begin
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Multiplier operand steering, one product per cycle.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            StDer1: begin mul_x = a_q;     mul_y = sat_sub(One, a_q); end
            StDer2: begin mul_x = err_q;   mul_y = t_q;               end
            StLrd:  begin mul_x = lr_q;    mul_y = delta_q;           end
            StUpd:  begin mul_x = ld_q;    mul_y = k_q[idx_q];        end
            StProp: begin mul_x = delta_q; mul_y = w_q[idx_q];        end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_out_q   <= '0;
            err_out_q <= '0;
            b_q       <= '0;
            a_q       <= '0;
            err_q     <= '0;
            lr_q      <= '0;
            t_q       <= '0;
            delta_q   <= '0;
            ld_q      <= '0;
            for (int j = 0; j < NUM; j++) begin
                k_q[j]    <= '0;
                w_q[j]    <= '0;
                wnew_q[j] <= '0;
                perr_q[j] <= '0;
            end
        end else begin
            busy_q <= (state_q != StIdle);
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        b_q   <= i_b;
                        a_q   <= i_a;
                        err_q <= i_err;
                        lr_q  <= i_lr;
                        for (int j = 0; j < NUM; j++) begin
                            k_q[j] <= i_k[j*WIDTH +: WIDTH];
                            w_q[j] <= i_w[j*WIDTH +: WIDTH];
                        end
                    end
                end
                StDer1: t_q     <= mul_p;
                StDer2: delta_q <= mul_p;
                StLrd:  ld_q    <= mul_p;
                StUpd:  wnew_q[idx_q] <= sat_sub(w_q[idx_q], mul_p);
                StProp: perr_q[idx_q] <= mul_p;
                StDone: begin
                    done_q <= 1'b1;
                    w_out_q[NUM*WIDTH +: WIDTH] <= sat_sub(b_q, ld_q);
                    for (int j = 0; j < NUM; j++) begin
                        w_out_q[j*WIDTH +: WIDTH]   <= wnew_q[j];
                        err_out_q[j*WIDTH +: WIDTH] <= perr_q[j];
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_wr   = done_q;
    assign o_w    = w_out_q;
    assign o_err  = err_out_q;

endmodule

// File: tb/tb_perceptron_bp.sv
// Self-checking bench for perceptron_bp (NUM=2, WIDTH=32, FRAC=16) against a
// plain-arithmetic reference model.
module tb_perceptron_bp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [63:0] i_k = '0, i_w = '0;
    logic [31:0] i_b = '0, i_a = '0, i_err = '0, i_lr = '0;
    logic        o_busy, o_done, o_wr;
    logic [95:0] o_w;
    logic [63:0] o_err;

    int passed = 0;
    int total  = 0;

    perceptron_bp #(
        .NUM   (2),
        .WIDTH (32),
        .FRAC  (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_k     (i_k),
        .i_w     (i_w),
        .i_b     (i_b),
        .i_a     (i_a),
        .i_err   (i_err),
        .i_lr    (i_lr),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_wr    (o_wr),
        .o_w     (o_w),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] clamp(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
        return v[31:0];
    endfunction

    function automatic logic [31:0] fm(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return clamp(p >>> 16);
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] x, input logic [31:0] y);
        return clamp(longint'($signed(x)) - longint'($signed(y)));
    endfunction

    function automatic void model(input logic [63:0] k, input logic [63:0] w,
                                  input logic [31:0] b, input logic [31:0] a,
                                  input logic [31:0] err, input logic [31:0] lr,
                                  output logic [95:0] ow, output logic [63:0] oe);
        logic [31:0] delta, ld;
        delta = fm(err, fm(a, fsub(32'h10000, a)));
        ld    = fm(lr, delta);
        for (int j = 0; j < 2; j++) begin
            ow[j*32 +: 32] = fsub(w[j*32 +: 32], fm(ld, k[j*32 +: 32]));
            oe[j*32 +: 32] = fm(delta, w[j*32 +: 32]);
        end
        ow[64 +: 32] = fsub(b, ld);
    endfunction

    function automatic logic [31:0] rnd_fx();
        logic [17:0] r;
        r = 18'($urandom);
        return {{14{r[17]}}, r};
    endfunction

    task automatic randomize_inputs();
        i_k   = {rnd_fx(), rnd_fx()};
        i_w   = {rnd_fx(), rnd_fx()};
        i_b   = rnd_fx();
        i_a   = 32'($urandom_range(0, 32'h10000));
        i_err = rnd_fx();
        i_lr  = 32'($urandom_range(0, 32'h8000));
    endtask

    // Called at a negedge; returns cycles from the accepting edge to o_done.
    task automatic launch(output int cyc, output logic busy0, output logic busy1);
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        cyc   = 0;
        busy0 = o_busy;
        busy1 = 1'b0;
        while (o_done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy1 = o_busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else passed++;
        total++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else passed++;
        total++; if (o_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", o_wr); else passed++;
        total++; if (o_w !== 96'h0) $display("FAIL reset_w: got %h want 0", o_w); else passed++;
        total++; if (o_err !== 64'h0) $display("FAIL reset_err: got %h want 0", o_err); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int cyc;
        logic b0, b1;
        i_a = 32'h8000; i_err = 32'h10000; i_lr = 32'h10000; i_b = 32'h0;
        i_k = {32'h20000, 32'h10000};
        i_w = {32'hFFFF8000, 32'h8000};
        launch(cyc, b0, b1);
        total++; if (cyc != 8) $display("FAIL nom_latency: got %0d want 8", cyc); else passed++;
        total++; if (b0 !== 1'b0) $display("FAIL nom_busy_e0: got %b want 0", b0); else passed++;
        total++; if (b1 !== 1'b1) $display("FAIL nom_busy_e1: got %b want 1", b1); else passed++;
        total++; if (o_wr !== 1'b1) $display("FAIL nom_wr: got %b want 1", o_wr); else passed++;
        total++; if (o_busy !== 1'b1) $display("FAIL nom_busy_done: got %b want 1", o_busy); else passed++;
        total++;
        if (o_w !== 96'hFFFFC000_FFFF0000_00004000)
            $display("FAIL nom_w: got %h want FFFFC000FFFF000000004000", o_w);
        else passed++;
        total++;
        if (o_err !== 64'hFFFFE000_00002000)
            $display("FAIL nom_err: got %h want FFFFE00000002000", o_err);
        else passed++;
        @(posedge clk); @(negedge clk);
        total++; if (o_done !== 1'b0) $display("FAIL nom_done_pulse: got %b want 0", o_done); else passed++;
        total++; if (o_busy !== 1'b0) $display("FAIL nom_busy_drop: got %b want 0", o_busy); else passed++;
        i_w = '1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        total++;
        if (o_w !== 96'hFFFFC000_FFFF0000_00004000)
            $display("FAIL nom_w_hold: got %h want FFFFC000FFFF000000004000", o_w);
        else passed++;
    endtask

    task automatic test_saturation();
        int cyc;
        logic b0, b1;
        logic [95:0] ew;
        logic [63:0] ee;
        i_a = 32'h8000; i_err = 32'hFFFF0000; i_lr = 32'h10000; i_b = rnd_fx();
        i_k = {rnd_fx(), 32'h10000};
        i_w = {rnd_fx(), 32'h7FFFFFFF};
        model(i_k, i_w, i_b, i_a, i_err, i_lr, ew, ee);
        launch(cyc, b0, b1);
        total++; if (o_w[31:0] !== 32'h7FFFFFFF) $display("FAIL sat_w0: got %h want 7FFFFFFF", o_w[31:0]); else passed++;
        total++; if (o_w !== ew) $display("FAIL sat_w: got %h want %h", o_w, ew); else passed++;
        total++; if (o_err !== ee) $display("FAIL sat_err: got %h want %h", o_err, ee); else passed++;
    endtask

    task automatic test_zero_deriv();
        int cyc;
        logic b0, b1;
        logic [95:0] ew;
        randomize_inputs();
        i_a = 32'h10000;
        i_err = $urandom;
        ew = {i_b, i_w};
        launch(cyc, b0, b1);
        total++; if (o_w !== ew) $display("FAIL zero_w: got %h want %h", o_w, ew); else passed++;
        total++; if (o_err !== 64'h0) $display("FAIL zero_err: got %h want 0", o_err); else passed++;
    endtask

    task automatic test_random();
        int cyc;
        logic b0, b1;
        logic [95:0] ew;
        logic [63:0] ee;
        for (int i = 0; i < 6; i++) begin
            randomize_inputs();
            if (i % 2 == 1) begin
                i_w   = {32'($urandom), 32'($urandom)};
                i_err = 32'($urandom);
                i_lr  = 32'($urandom_range(0, 32'h7FFFFFFF));
            end
            model(i_k, i_w, i_b, i_a, i_err, i_lr, ew, ee);
            launch(cyc, b0, b1);
            total++; if (cyc != 8) $display("FAIL rnd%0d_latency: got %0d want 8", i, cyc); else passed++;
            total++; if (o_w !== ew) $display("FAIL rnd%0d_w: got %h want %h", i, o_w, ew); else passed++;
            total++; if (o_err !== ee) $display("FAIL rnd%0d_err: got %h want %h", i, o_err, ee); else passed++;
        end
    endtask

    task automatic test_ignore_start();
        logic [95:0] ew, gw;
        logic [63:0] ee, ge;
        int dones, done_at;
        randomize_inputs();
        model(i_k, i_w, i_b, i_a, i_err, i_lr, ew, ee);
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dones = 0; done_at = -1; gw = '0; ge = '0;
        for (int c = 1; c <= 20; c++) begin
            i_start = (c == 3 || c == 5);
            randomize_inputs();
            @(posedge clk);
            @(negedge clk);
            if (o_done === 1'b1) begin
                dones++;
                done_at = c;
                gw = o_w;
                ge = o_err;
            end
        end
        i_start = 1'b0;
        total++; if (dones != 1) $display("FAIL ign_count: got %0d want 1", dones); else passed++;
        total++; if (done_at != 8) $display("FAIL ign_latency: got %0d want 8", done_at); else passed++;
        total++; if (gw !== ew) $display("FAIL ign_w: got %h want %h", gw, ew); else passed++;
        total++; if (ge !== ee) $display("FAIL ign_err: got %h want %h", ge, ee); else passed++;
    endtask

    task automatic test_reset_mid();
        int cyc, wrs;
        logic b0, b1;
        logic [95:0] ew;
        logic [63:0] ee;
        randomize_inputs();
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (o_busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", o_busy); else passed++;
        total++; if (o_wr !== 1'b0) $display("FAIL rmid_wr: got %b want 0", o_wr); else passed++;
        total++; if (o_w !== 96'h0) $display("FAIL rmid_w: got %h want 0", o_w); else passed++;
        total++; if (o_err !== 64'h0) $display("FAIL rmid_err: got %h want 0", o_err); else passed++;
        wrs = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (o_wr === 1'b1) wrs++;
        end
        total++; if (wrs != 0) $display("FAIL rmid_no_wr: got %0d want 0", wrs); else passed++;
        randomize_inputs();
        model(i_k, i_w, i_b, i_a, i_err, i_lr, ew, ee);
        launch(cyc, b0, b1);
        total++; if (cyc != 8) $display("FAIL rmid_latency: got %0d want 8", cyc); else passed++;
        total++; if (o_w !== ew) $display("FAIL rmid_fresh_w: got %h want %h", o_w, ew); else passed++;
        total++; if (o_err !== ee) $display("FAIL rmid_fresh_err: got %h want %h", o_err, ee); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [95:0] qw [$];
        logic [63:0] qe [$];
        logic [95:0] ew;
        logic [63:0] ee;
        int last, nd;
        randomize_inputs();
        model(i_k, i_w, i_b, i_a, i_err, i_lr, ew, ee);
        qw.push_back(ew);
        qe.push_back(ee);
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        last = 0; nd = 0;
        for (int c = 1; c <= 48; c++) begin
            if (c % 9 == 2 && c < 30) begin
                randomize_inputs();
                model(i_k, i_w, i_b, i_a, i_err, i_lr, ew, ee);
                qw.push_back(ew);
                qe.push_back(ee);
            end
            if (c == 38) i_start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (o_done === 1'b1) begin
                total++;
                if (c - last != ((nd == 0) ? 8 : 9))
                    $display("FAIL b2b%0d_interval: got %0d want %0d", nd, c - last,
                             (nd == 0) ? 8 : 9);
                else passed++;
                total++; if (o_wr !== 1'b1) $display("FAIL b2b%0d_wr: got %b want 1", nd, o_wr); else passed++;
                total++;
                if (qw.size() == 0) begin
                    $display("FAIL b2b%0d_extra: got done with %0d pending want pending result", nd, 0);
                end else begin
                    ew = qw.pop_front();
                    ee = qe.pop_front();
                    if (o_w !== ew || o_err !== ee)
                        $display("FAIL b2b%0d_result: got %h/%h want %h/%h", nd, o_w, o_err, ew, ee);
                    else passed++;
                end
                last = c;
                nd++;
            end
        end
        total++; if (nd != 5) $display("FAIL b2b_count: got %0d want 5", nd); else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_saturation();
        test_zero_deriv();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
